cordic_nco_scheduler: RTL and testbench
=======================================

// Module: cordic_nco_scheduler
// PURPOSE
//  Time-multiplexes one shared cordic sin/cos pipeline between N_CH NCO channels.
//  Holds per-channel tuning word, phase offset and 32-bit phase accumulator.
//  Issues one phase per cycle, round-robin over enabled channels.
//  Tags every issue with its channel, and returns tagged sin/cos through an output
//  FIFO with ready/valid backpressure. Credit gating means the pipeline can never overflow.
// PARAMETERS
//  N_CH       4   number of NCO channels (2..16)
//  CH_W       2   channel index width, clog2(N_CH)
//  OUT_DEPTH  32  output FIFO depth, power of 2, must be >= cordic latency + 2
// PORTS
//  clk_i          in   1   clock
//  rst_i          in   1   asynchronous active-high reset
//  run_i          in   1   level; 1 = schedule channels, 0 = stop issuing and drain
//  cfg_we_i       in   1   config write strobe (one cycle)
//  cfg_ch_i       in   CH_W  channel being configured
//  cfg_ftw_i      in   32  frequency tuning word (phase step per service)
//  cfg_off_i      in   32  phase offset added at issue
//  cfg_en_i       in   1   channel enable
//  cfg_clr_i      in   1   clear channel accumulator to 0
//  cordic_valid_o out  1   phase valid to cordic
//  cordic_phase_o out  32  phase to cordic (2^32 = 2*pi)
//  cordic_valid_i in   1   result valid from cordic
//  cordic_sin_i   in   16  signed sin from cordic
//  cordic_cos_i   in   16  signed cos from cordic
//  out_valid_o    out  1   output sample valid
//  out_ready_i    in   1   downstream ready
//  out_ch_o       out  CH_W  channel tag of output sample
//  out_sin_o      out  16  signed sin
//  out_cos_o      out  16  signed cos
//  busy_o         out  1   state != IDLE
//  err_o          out  1   sticky: result arrived with no tag pending
// BEHAVIOUR
//  Reset: all outputs 0.
//   All accumulators, FTW and offset registers, and enables are 0; the FIFOs are empty.
//   The round-robin pointer is at N_CH-1, so channel 0 is served first. State is IDLE.
//  FSM:
//   IDLE  -> RUN when run_i=1.
//   RUN   -> DRAIN when run_i=0.
//   DRAIN -> IDLE when inflight=0 and output FIFO is empty.
//   DRAIN -> RUN when run_i=1.
//  Credits:
//   inflight = tags issued but not yet returned.
//   Issue is allowed only if inflight + FIFO occupancy < OUT_DEPTH.
//  Issue (RUN only, at most one per cycle):
//   Pick the first enabled channel after the pointer, wrapping modulo N_CH.
//   At the next edge: cordic_valid_o=1 and cordic_phase_o = acc[ch] + off[ch] (mod 2^32).
//   In the same edge: acc[ch] <= acc[ch] + ftw[ch] (wrap), pointer <= ch, and ch is pushed to the tag FIFO.
//   No enabled channel or no credit: cordic_valid_o=0 and cordic_phase_o holds its last value.
//  Config:
//   A write takes effect at the edge. An issue to the same channel in that cycle uses the old ftw and offset.
//   cfg_clr_i wins over the accumulator update, so acc becomes 0.
//   A write is accepted in any state. cfg_en_i=0 only stops future issues; samples already in flight still return.
//  Return:
//   On cordic_valid_i, pop the tag FIFO and push {tag, sin, cos} to the output FIFO.
//   If the tag FIFO is empty, discard the result and set err_o (cleared only by reset).
//  Output:
//   The output FIFO is first-word fall-through, visible the cycle after the push.
//   Pop occurs on out_valid_o & out_ready_i. Simultaneous push and pop keep the count unchanged.
//   Data is held stable while out_valid_o=1 and out_ready_i=0.
//  Reset mid-operation clears everything immediately. The cordic must be reset by the same rst_i.
// TESTING
//  1. Only ch0 enabled, ftw=0x01000000, off=0, run=1:
//     cordic_phase_o = 0x00000000, 0x01000000, 0x02000000, ... on consecutive cycles.
//     Out samples are tagged ch0, and sin of sample k matches sin(2*pi*k/256) within 2 LSB.
//  2. 4 channels enabled, ftw=0x40000000 on all:
//     issue order ch0,ch1,ch2,ch3,ch0,...; every channel sees phases 0, pi/2, pi, ...
//     The first ch1 sample has cos ~ +32767, sin ~ 0.
//  3. out_ready_i=0 with run=1:
//     exactly OUT_DEPTH issues, then cordic_valid_o stays 0 and nothing is lost.
//     After ready=1, all OUT_DEPTH samples drain in order and issuing resumes.
//  4. ch0 off=0x80000000, ftw=0, cfg_clr pulse mid-stream:
//     phase stays 0x80000000 (sin ~ 0, cos ~ -32767).
//     A clr coinciding with an issue gives that issue the old phase; the next issue starts from acc=0.
//  5. run_i dropped with 10 in flight:
//     busy_o stays 1 until all 10 outputs are popped, then goes to IDLE.
//     Raising run_i during DRAIN resumes without losing the round-robin position.
//  6. cordic_valid_i pulsed with no outstanding tag -> err_o=1 and the output FIFO is unchanged.
//     rst_i asserted mid-stream -> all outputs 0 asynchronously, and after release the issue order restarts at ch0.

Source files
------------

// File: rtl/cordic_nco_scheduler.sv
// Shares one cordic sin/cos pipeline round-robin between N_CH NCO channels; results return through a tagged FWFT FIFO.
// Issue latency 1 cycle; credits bound inflight+queued results to OUT_DEPTH so a stalled output only pauses issuing.
module cordic_nco_scheduler #(
    parameter int N_CH      = 4,
    parameter int CH_W      = 2,
    parameter int OUT_DEPTH = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              run_i,
    input  logic              cfg_we_i,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [31:0]       cfg_ftw_i,
    input  logic [31:0]       cfg_off_i,
    input  logic              cfg_en_i,
    input  logic              cfg_clr_i,
    output logic              cordic_valid_o,
    output logic [31:0]       cordic_phase_o,
    input  logic              cordic_valid_i,
    input  logic [15:0]       cordic_sin_i,
    input  logic [15:0]       cordic_cos_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CH_W-1:0]   out_ch_o,
    output logic [15:0]       out_sin_o,
    output logic [15:0]       out_cos_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam int AW    = $clog2(OUT_DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int OW    = CH_W + 32;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(OUT_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [31:0]       r_acc [N_CH];
    logic [31:0]       r_ftw [N_CH];
    logic [31:0]       r_off [N_CH];
    logic [N_CH-1:0]   r_en;
    logic [CH_W-1:0]   r_ptr;

    logic [CH_W-1:0]   r_tag_mem [OUT_DEPTH];
    logic [AW-1:0]     r_tag_wp;
    logic [AW-1:0]     r_tag_rp;
    logic [CNT_W-1:0]  r_tag_cnt;

    logic [OW-1:0]     r_out_mem [OUT_DEPTH];
    logic [AW-1:0]     r_out_wp;
    logic [AW-1:0]     r_out_rp;
    logic [CNT_W-1:0]  r_out_cnt;

    logic              r_cordic_vld;
    logic [31:0]       r_cordic_phase;
    logic              r_err;

    logic              w_pick_vld;
    logic [CH_W-1:0]   w_pick_ch;
    logic              w_credit;
    logic              w_issue;
    logic              w_ret_ok;
    logic              w_out_vld;
    logic              w_out_pop;
    logic [N_CH-1:0]   w_cfg_hit;

    // Scan from furthest to nearest so the last hit is the first enabled channel after the pointer.
    always_comb begin
        int idx;
        idx        = 0;
        w_pick_vld = 1'b0;
        w_pick_ch  = '0;
        for (int i = N_CH; i >= 1; i--) begin
            idx = int'(r_ptr) + i;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (r_en[idx[CH_W-1:0]]) begin
                w_pick_vld = 1'b1;
                w_pick_ch  = idx[CH_W-1:0];
            end
        end
    end

    always_comb begin
        w_cfg_hit = '0;
        for (int c = 0; c < N_CH; c++) begin
            w_cfg_hit[c] = cfg_we_i && (cfg_ch_i == CH_W'(c));
        end
    end

    assign w_credit  = ({1'b0, r_tag_cnt} + {1'b0, r_out_cnt}) < DEPTH_C;
    assign w_issue   = (r_state == RUN) && w_pick_vld && w_credit;
    assign w_ret_ok  = cordic_valid_i && (r_tag_cnt != '0);
    assign w_out_vld = (r_out_cnt != '0);
    assign w_out_pop = w_out_vld && out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (run_i) w_state_nxt = RUN;
            RUN:     if (!run_i) w_state_nxt = DRAIN;
            DRAIN: begin
                if (run_i) begin
                    w_state_nxt = RUN;
                end else if ((r_tag_cnt == '0) && !w_out_vld) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Config writes and accumulator steps share one edge; reads on the right-hand side see pre-write values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < N_CH; c++) begin
                r_acc[c] <= '0;
                r_ftw[c] <= '0;
                r_off[c] <= '0;
            end
            r_en <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (w_cfg_hit[c]) begin
                    r_ftw[c] <= cfg_ftw_i;
                    r_off[c] <= cfg_off_i;
                    r_en[c]  <= cfg_en_i;
                end
                if (w_cfg_hit[c] && cfg_clr_i) begin
                    r_acc[c] <= '0;
                end else if (w_issue && (w_pick_ch == CH_W'(c))) begin
                    r_acc[c] <= r_acc[c] + r_ftw[c];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr          <= CH_W'(N_CH - 1);
            r_cordic_vld   <= 1'b0;
            r_cordic_phase <= '0;
            r_err          <= 1'b0;
        end else begin
            r_cordic_vld <= w_issue;
            if (w_issue) begin
                r_ptr          <= w_pick_ch;
                r_cordic_phase <= r_acc[w_pick_ch] + r_off[w_pick_ch];
            end
            if (cordic_valid_i && (r_tag_cnt == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tag_wp  <= '0;
            r_tag_rp  <= '0;
            r_tag_cnt <= '0;
            r_out_wp  <= '0;
            r_out_rp  <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_issue)   r_tag_wp <= r_tag_wp + 1'b1;
            if (w_ret_ok)  r_tag_rp <= r_tag_rp + 1'b1;
            r_tag_cnt <= r_tag_cnt + CNT_W'(w_issue) - CNT_W'(w_ret_ok);
            if (w_ret_ok)  r_out_wp <= r_out_wp + 1'b1;
            if (w_out_pop) r_out_rp <= r_out_rp + 1'b1;
            r_out_cnt <= r_out_cnt + CNT_W'(w_ret_ok) - CNT_W'(w_out_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_issue) begin
            r_tag_mem[r_tag_wp] <= w_pick_ch;
        end
        if (w_ret_ok) begin
            r_out_mem[r_out_wp] <= {r_tag_mem[r_tag_rp], cordic_sin_i, cordic_cos_i};
        end
    end

    assign cordic_valid_o = r_cordic_vld;
    assign cordic_phase_o = r_cordic_phase;
    assign out_valid_o    = w_out_vld;
    assign {out_ch_o, out_sin_o, out_cos_o} = w_out_vld ? r_out_mem[r_out_rp] : '0;
    assign busy_o         = (r_state != IDLE);
    assign err_o          = r_err;

endmodule

// File: tb/tb_cordic_nco_scheduler.sv
// Directed bench for cordic_nco_scheduler with a behavioural fixed-latency cordic model.
module tb_cordic_nco_scheduler;

    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [31:0] cfg_ftw = '0;
    logic [31:0] cfg_off = '0;
    logic        cfg_en = 1'b0;
    logic        cfg_clr = 1'b0;
    logic        cordic_valid_o;
    logic [31:0] cordic_phase_o;
    logic        cordic_valid_i;
    logic [15:0] cordic_sin_i;
    logic [15:0] cordic_cos_i;
    logic        out_valid_o;
    logic        out_ready = 1'b1;
    logic [1:0]  out_ch_o;
    logic [15:0] out_sin_o;
    logic [15:0] out_cos_o;
    logic        busy_o;
    logic        err_o;
    logic        inj = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int cnt;

    typedef struct {
        logic [1:0] ch;
        int         s;
        int         c;
    } smp_t;

    logic [31:0] iss_q [$];
    smp_t        out_q [$];
    smp_t        mon_s;

    cordic_nco_scheduler #(.N_CH(4), .CH_W(2), .OUT_DEPTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .run_i(run),
        .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch), .cfg_ftw_i(cfg_ftw), .cfg_off_i(cfg_off),
        .cfg_en_i(cfg_en), .cfg_clr_i(cfg_clr),
        .cordic_valid_o(cordic_valid_o), .cordic_phase_o(cordic_phase_o),
        .cordic_valid_i(cordic_valid_i), .cordic_sin_i(cordic_sin_i), .cordic_cos_i(cordic_cos_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready), .out_ch_o(out_ch_o),
        .out_sin_o(out_sin_o), .out_cos_o(out_cos_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] trig(input logic [31:0] p, input logic is_cos);
        real a;
        real r;
        int  v;
        a = 2.0 * 3.14159265358979 * real'(p) / 4294967296.0;
        r = is_cos ? 32767.0 * $cos(a) : 32767.0 * $sin(a);
        v = (r >= 0.0) ? $rtoi(r + 0.5) : $rtoi(r - 0.5);
        return v[15:0];
    endfunction

    logic [LAT-1:0] pv;
    logic [15:0]    ps [LAT];
    logic [15:0]    pc [LAT];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pv <= '0;
        end else begin
            pv    <= {pv[LAT-2:0], cordic_valid_o};
            ps[0] <= trig(cordic_phase_o, 1'b0);
            pc[0] <= trig(cordic_phase_o, 1'b1);
            for (int i = 1; i < LAT; i++) begin
                ps[i] <= ps[i-1];
                pc[i] <= pc[i-1];
            end
        end
    end

    assign cordic_valid_i = pv[LAT-1] | inj;
    assign cordic_sin_i   = ps[LAT-1];
    assign cordic_cos_i   = pc[LAT-1];

    always @(negedge clk) begin
        if (cordic_valid_o) iss_q.push_back(cordic_phase_o);
        if (out_valid_o && out_ready) begin
            mon_s.ch = out_ch_o;
            mon_s.s  = int'($signed(out_sin_o));
            mon_s.c  = int'($signed(out_cos_o));
            out_q.push_back(mon_s);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input int obs, input int exp);
        logic near;
        near = (obs >= exp - 2) && (obs <= exp + 2);
        vectors++;
        assert (near === 1'b1) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d(+-2)", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [31:0] ftw, input logic [31:0] off,
                       input logic en, input logic clr);
        cfg_ch = ch; cfg_ftw = ftw; cfg_off = off; cfg_en = en; cfg_clr = clr;
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
        cfg_clr = 1'b0;
    endtask

    task automatic do_reset();
        run = 1'b0;
        out_ready = 1'b1;
        #2 rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        tick();
        iss_q.delete();
        out_q.delete();
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy_o && n < 1000) begin
            tick();
            n++;
        end
        chk(tag, 32'(busy_o), 32'd0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_cvld"},  32'(cordic_valid_o), 32'd0);
        chk({tag, "_phase"}, cordic_phase_o, 32'd0);
        chk({tag, "_ovld"},  32'(out_valid_o), 32'd0);
        chk({tag, "_osin"},  32'({out_ch_o, out_sin_o, out_cos_o}), 32'd0);
        chk({tag, "_busy"},  32'(busy_o), 32'd0);
        chk({tag, "_err"},   32'(err_o), 32'd0);
    endtask

    initial begin
        #50_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2 rst = 1'b1;
        #1;
        chk_zero_outputs("rst_async");
        do_reset();
        chk_zero_outputs("rst");

        // 1: single channel phase ramp
        cfg(2'd0, 32'h0100_0000, 32'h0, 1'b1, 1'b0);
        run = 1'b1;
        ticks(80);
        run = 1'b0;
        wait_idle("t1_idle");
        for (int k = 0; k < 4; k++) chk("t1_phase", iss_q[k], 32'(k) * 32'h0100_0000);
        chk("t1_count", 32'(out_q.size()), 32'(iss_q.size()));
        chk("t1_tag", 32'(out_q[16].ch), 32'd0);
        chk_near("t1_sin0", out_q[0].s, 0);
        chk_near("t1_sin32", out_q[32].s, 23170);
        chk_near("t1_sin64", out_q[64].s, 32767);

        // 2: four channels, quarter-turn steps
        do_reset();
        for (int c = 0; c < 4; c++) cfg(2'(c), 32'h4000_0000, 32'h0, 1'b1, 1'b0);
        run = 1'b1;
        ticks(20);
        run = 1'b0;
        wait_idle("t2_idle");
        for (int i = 0; i < 12; i++) chk("t2_phase", iss_q[i], 32'(i / 4) * 32'h4000_0000);
        for (int i = 0; i < 8; i++) chk("t2_tag", 32'(out_q[i].ch), 32'(i % 4));
        chk_near("t2_ch1_cos", out_q[1].c, 32767);
        chk_near("t2_ch1_sin", out_q[1].s, 0);
        chk_near("t2_ch1_sin_q", out_q[5].s, 32767);
        chk_near("t2_ch2_cos_pi", out_q[10].c, -32767);

        // 3: output backpressure exhausts credits
        do_reset();
        cfg(2'd0, 32'h0100_0000, 32'h0, 1'b1, 1'b0);
        out_ready = 1'b0;
        run = 1'b1;
        ticks(60);
        chk("t3_issues", 32'(iss_q.size()), 32'd32);
        chk("t3_ovld", 32'(out_valid_o), 32'd1);
        chk("t3_head_cos", 32'(out_cos_o), 32'h7FFF);
        ticks(40);
        chk("t3_issues_hold", 32'(iss_q.size()), 32'd32);
        chk("t3_head_hold", {out_ch_o, out_sin_o, out_cos_o}, {2'd0, 16'h0, 16'h7FFF});
        out_ready = 1'b1;
        ticks(40);
        chk("t3_resume", 32'(iss_q.size() > 32), 32'd1);
        run = 1'b0;
        wait_idle("t3_idle");
        chk("t3_lossless", 32'(out_q.size()), 32'(iss_q.size()));
        chk_near("t3_sin16", out_q[16].s, 12539);
        chk_near("t3_sin31", out_q[31].s, 22594);
        chk_near("t3_sin32", out_q[32].s, 23170);

        // 4: offset, late ftw change and clear
        do_reset();
        cfg(2'd0, 32'h0, 32'h8000_0000, 1'b1, 1'b0);
        run = 1'b1;
        ticks(4);
        chk("t4_vld", 32'(cordic_valid_o), 32'd1);
        chk("t4_phase_a", cordic_phase_o, 32'h8000_0000);
        tick();
        chk("t4_phase_b", cordic_phase_o, 32'h8000_0000);
        cfg(2'd0, 32'h0010_0000, 32'h8000_0000, 1'b1, 1'b0);
        chk("t4_ftw_e0", cordic_phase_o, 32'h8000_0000);
        tick();
        chk("t4_ftw_e1_old", cordic_phase_o, 32'h8000_0000);
        tick();
        chk("t4_ftw_e2_new", cordic_phase_o, 32'h8010_0000);
        ticks(3);
        chk("t4_pre_clr", cordic_phase_o, 32'h8040_0000);
        cfg(2'd0, 32'h0010_0000, 32'h8000_0000, 1'b1, 1'b1);
        chk("t4_clr_old", cordic_phase_o, 32'h8050_0000);
        tick();
        chk("t4_clr_next", cordic_phase_o, 32'h8000_0000);
        tick();
        chk("t4_clr_step", cordic_phase_o, 32'h8010_0000);
        run = 1'b0;
        wait_idle("t4_idle");
        chk_near("t4_sin", out_q[0].s, 0);
        chk_near("t4_cos", out_q[1].c, -32767);

        // 5: drain with 10 in flight, then resume from drain
        do_reset();
        for (int c = 0; c < 4; c++) cfg(2'(c), 32'h4000_0000, 32'h0, 1'b1, 1'b0);
        out_ready = 1'b0;
        run = 1'b1;
        cnt = 0;
        for (int i = 0; i < 50 && cnt < 9; i++) begin
            tick();
            if (cordic_valid_o) cnt++;
        end
        run = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cordic_valid_o) cnt++;
        end
        chk("t5_inflight", 32'(cnt), 32'd10);
        chk("t5_busy", 32'(busy_o), 32'd1);
        out_ready = 1'b1;
        ticks(5);
        out_ready = 1'b0;
        chk("t5_popped", 32'(out_q.size()), 32'd5);
        chk("t5_busy_part", 32'(busy_o), 32'd1);
        run = 1'b1;
        cnt = 0;
        while (!cordic_valid_o && cnt < 5) begin
            tick();
            cnt++;
        end
        chk("t5_resume_phase", cordic_phase_o, 32'h8000_0000);
        out_ready = 1'b1;
        ticks(20);
        run = 1'b0;
        wait_idle("t5_idle");
        chk("t5_lossless", 32'(out_q.size()), 32'(iss_q.size()));
        chk("t5_tag9", 32'(out_q[9].ch), 32'd1);
        chk("t5_tag10", 32'(out_q[10].ch), 32'd2);

        // 6: orphan result and asynchronous reset
        inj = 1'b1;
        tick();
        inj = 1'b0;
        chk("t6_err", 32'(err_o), 32'd1);
        chk("t6_fifo", 32'(out_valid_o), 32'd0);
        tick();
        chk("t6_err_sticky", 32'(err_o), 32'd1);
        for (int c = 0; c < 4; c++) cfg(2'(c), 32'h4000_0000, 32'h0, 1'b1, 1'b0);
        run = 1'b1;
        ticks(8);
        #2 rst = 1'b1;
        #1;
        chk_zero_outputs("t6_rst");
        tick();
        rst = 1'b0;
        iss_q.delete();
        out_q.delete();
        for (int c = 0; c < 4; c++) cfg(2'(c), 32'h4000_0000, 32'h0, 1'b1, 1'b0);
        ticks(8);
        run = 1'b0;
        wait_idle("t6_idle");
        chk("t6_first_ch", 32'(out_q[0].ch), 32'd0);
        chk("t6_second_ch", 32'(out_q[1].ch), 32'd1);
        chk("t6_first_phase", iss_q[0], 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
